clk_div_sched: RTL and testbench

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

---
 rtl/clk_div_sched.sv | 134 +++++++++++++
 tb/tb_clk_div_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Glitch-free programmable clock divider with hitless ratio scheduling.
// Define CLK_DIV_SCHED_PERIOD_CNT_EN to add the period_cnt output.
module clk_div_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_req,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_rdy,
  output logic             div_out,
  output logic             div_tick,
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             div_out_q, div_out_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cur_m1;
  logic [WIDTH:0]   half_d;
  logic             last;
  logic             xfer;
  logic             load;

  assign cur_m1   = cur_q - WIDTH'(1);
  assign last     = busy_q && (cnt_q == cur_m1);
  assign div_rdy  = (state_q != PEND);
  assign xfer     = div_req && div_rdy;
  assign div_tick = last;
  assign div_out  = div_out_q;
  assign busy     = busy_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer && (div_val != '0)) begin
          state_d = RUN;
          cur_d   = div_val;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (last) begin
          cnt_d = '0;
          if (xfer) begin
            load    = 1'b1;
            cur_d   = div_val;
            state_d = (div_val == '0) ? IDLE : RUN;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          if (xfer) begin
            nxt_d   = div_val;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (last) begin
          cnt_d   = '0;
          load    = 1'b1;
          cur_d   = nxt_q;
          nxt_d   = '0;
          state_d = (nxt_q == '0) ? IDLE : RUN;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cur_d   = '0;
        nxt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    // Output registers look ahead at the next state so they stay glitch-free.
    busy_d    = (state_d != IDLE);
    half_d    = ({1'b0, cur_d} + (WIDTH+1)'(1)) >> 1;
    div_out_d = busy_d && ({1'b0, cnt_d} < half_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      nxt_q     <= '0;
      cnt_q     <= '0;
      div_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
      busy_q    <= busy_d;
    end
  end

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
  logic [15:0] pcnt_q;

  assign period_cnt = pcnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else if (load) begin
      pcnt_q <= '0;
    end else if (div_tick && (pcnt_q != 16'hFFFF)) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: period-level reference model,
// directed ratio-change scenarios followed by randomized traffic.
module tb_clk_div_sched;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [7:0] val;
  logic       rdy;
  logic       dout;
  logic       tick;
  logic       bsy;
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
  logic [15:0] pcnt;
`endif

  clk_div_sched #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .div_req    (req),
    .div_val    (val),
    .div_rdy    (rdy),
    .div_out    (dout),
    .div_tick   (tick),
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    .period_cnt (pcnt),
`endif
    .busy       (bsy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit out;
    bit tick;
    bit rdy;
    bit busy;
    int pc;
  } exp_t;

  exp_t exq[$];
  int   compared = 0;
  int   mismatched = 0;

  // Reference: per = active period length (0 = stopped),
  // pos = cycle index inside it, pend = queued ratio (-1 = none).
  int per  = 0;
  int pos  = 0;
  int pend = -1;
  int pc   = 0;

  always @(posedge clk) begin
    bit   xfer;
    bit   otick;
    bit   ld;
    exp_t e;
    otick = (per > 0) && (pos == per - 1);
    xfer  = req && (pend < 0);
    ld    = 0;
    if (!rst_n) begin
      per = 0; pos = 0; pend = -1; pc = 0;
    end else begin
      if (per == 0) begin
        if (xfer && val > 0) begin
          per = int'(val); pos = 0; ld = 1;
        end
      end else if (pos == per - 1) begin
        pos = 0;
        if (pend >= 0) begin
          per = pend; pend = -1; ld = 1;
        end else if (xfer) begin
          per = int'(val); ld = 1;
        end
      end else begin
        pos = pos + 1;
        if (xfer) pend = int'(val);
      end
      if (ld) pc = 0;
      else if (otick && pc < 65535) pc = pc + 1;
    end
    e.busy = (per > 0);
    e.out  = (per > 0) && (pos < (per + 1) / 2);
    e.tick = (per > 0) && (pos == per - 1);
    e.rdy  = (pend < 0);
    e.pc   = pc;
    exq.push_back(e);
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      chk("div_out", int'(dout), int'(e.out));
      chk("div_tick", int'(tick), int'(e.tick));
      chk("div_rdy", int'(rdy), int'(e.rdy));
      chk("busy", int'(bsy), int'(e.busy));
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
      chk("period_cnt", int'(pcnt), e.pc);
`endif
    end
  end

  task automatic hold(input logic r, input logic q,
                      input logic [7:0] v, input int n);
    rst_n = r;
    req   = q;
    val   = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    val   = '0;
    hold(0, 0, 0, 3);
    hold(1, 0, 0, 20);
    // N=6 then N=5 from idle-like transfers on period boundaries
    hold(1, 1, 6, 1);
    hold(1, 0, 0, 12);
    hold(1, 1, 0, 1);
    hold(1, 0, 0, 8);
    hold(1, 1, 5, 1);
    hold(1, 0, 0, 10);
    hold(1, 1, 0, 1);
    hold(1, 0, 0, 6);
    // N=6 running, request N=4 at cnt=1 held high through PEND
    hold(1, 1, 6, 1);
    hold(1, 0, 0, 1);
    hold(1, 1, 4, 8);
    hold(1, 0, 0, 12);
    hold(1, 1, 0, 1);
    hold(1, 0, 0, 8);
    // N=4, then N=8 exactly on the cnt=3 cycle
    hold(1, 1, 4, 1);
    hold(1, 0, 0, 3);
    hold(1, 1, 8, 1);
    hold(1, 0, 0, 3);
    hold(1, 1, 0, 1);
    hold(1, 0, 0, 12);
    // pass-through, then stop
    hold(1, 1, 1, 1);
    hold(1, 0, 0, 6);
    hold(1, 1, 0, 1);
    hold(1, 0, 0, 3);
    // reset pulsed while a ratio is pending
    hold(1, 1, 9, 1);
    hold(1, 0, 0, 2);
    hold(1, 1, 3, 1);
    hold(0, 0, 0, 1);
    hold(1, 0, 0, 12);
    // N=2 for ten periods, then change ratio
    hold(1, 1, 2, 1);
    hold(1, 0, 0, 20);
    hold(1, 1, 3, 1);
    hold(1, 0, 0, 8);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       q;
      logic [7:0] v;
      r = ($urandom_range(0, 99) != 0);
      q = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) v = 8'($urandom_range(0, 255));
      else v = 8'($urandom_range(0, 9));
      hold(r, q, v, 1);
    end
    hold(1, 0, 0, 4);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
